// File: rtl/csa_multiword_seq_pkg.sv
// rtl/csa_multiword_seq_pkg.sv - shared constants for the multi-word add/sub sequencer
//
// Purpose : word width and FSM state encoding shared by the sequencer and its adder.
// Ports   : none (package).

package csa_multiword_seq_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/csa_multiword_seq_csa32.sv
// rtl/csa_multiword_seq_csa32.sv - 32-bit carry-select adder with per-bit carry vector
//
// Purpose : s = a + b + c_in; c[i] is the carry out of bit i, so c[31] is the word
//           carry-out and c[30]^c[31] is the signed overflow of the word.
// Ports   : a, b   - 32-bit addends
//           c_in   - carry into bit 0
//           s      - 32-bit sum
//           c      - per-bit carry-out vector

module csa32
   import csa_multiword_seq_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              c_in,
   output logic [WORD_W-1:0] s,
   output logic [WORD_W-1:0] c
);

   localparam int BLK = 4;
   localparam int NB  = WORD_W / BLK;

   // Each block is summed twice, once assuming carry-in 0 and once carry-in 1;
   // the real block carry-in then only has to pick one of the two.
   logic [WORD_W-1:0] s0, c0, s1, c1;
   logic [NB-1:0]     blk_cin;

   always_comb begin
      logic r0, r1;
      s0 = '0;
      c0 = '0;
      s1 = '0;
      c1 = '0;
      r0 = 1'b0;
      r1 = 1'b0;
      for (int k = 0; k < NB; k++) begin
         r0 = 1'b0;
         r1 = 1'b1;
         for (int j = 0; j < BLK; j++) begin
            s0[k*BLK+j] = a[k*BLK+j] ^ b[k*BLK+j] ^ r0;
            r0          = (a[k*BLK+j] & b[k*BLK+j]) | (r0 & (a[k*BLK+j] ^ b[k*BLK+j]));
            c0[k*BLK+j] = r0;
            s1[k*BLK+j] = a[k*BLK+j] ^ b[k*BLK+j] ^ r1;
            r1          = (a[k*BLK+j] & b[k*BLK+j]) | (r1 & (a[k*BLK+j] ^ b[k*BLK+j]));
            c1[k*BLK+j] = r1;
         end
      end
   end

   assign blk_cin[0] = c_in;

   for (genvar k = 0; k < NB; k++) begin : g_sel
      if (k > 0) begin : g_chain
         assign blk_cin[k] = c[k*BLK-1];
      end
      assign s[k*BLK +: BLK] = blk_cin[k] ? s1[k*BLK +: BLK] : s0[k*BLK +: BLK];
      assign c[k*BLK +: BLK] = blk_cin[k] ? c1[k*BLK +: BLK] : c0[k*BLK +: BLK];
   end

endmodule

// File: rtl/csa_multiword_seq.sv
// rtl/csa_multiword_seq.sv - multi-word add/sub sequencer over one shared csa32
//
// Purpose : WORDS x 32-bit add (a+b+c_in) or subtract (a-b-c_in), one word per
//           cycle LSW first, carry held in a register between words.
// Ports   : clk, rst                  - clock, async active-high reset
//           start_valid/start_ready   - command handshake (op_sub, a, b, c_in)
//           flush                     - synchronous abort, clears result
//           result_valid/result_ready - result handshake (sum, c_out, ovf)
//           busy                      - state is not IDLE

module csa_multiword_seq
   import csa_multiword_seq_pkg::*;
#(
   parameter int WORDS = 4,
   parameter int CNT_W = $clog2(WORDS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic                    op_sub,
   input  logic [WORDS*WORD_W-1:0] a,
   input  logic [WORDS*WORD_W-1:0] b,
   input  logic                    c_in,
   input  logic                    flush,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [WORDS*WORD_W-1:0] sum,
   output logic                    c_out,
   output logic                    ovf,
   output logic                    busy
);

   logic [1:0]                     state;
   logic [CNT_W-1:0]               idx;
   logic                           carry;
   logic [WORDS-1:0][WORD_W-1:0]   a_reg, b_reg, sum_reg;
   logic [WORD_W-1:0]              add_s;
   logic [1:0]                     add_c_top;
   logic [WORD_W-3:0]              add_c_unused;
   logic                           last_word;

   csa32 u_csa32 (
      .a    (a_reg[idx]),
      .b    (b_reg[idx]),
      .c_in (carry),
      .s    (add_s),
      .c    ({add_c_top, add_c_unused})
   );

   assign last_word    = (idx == CNT_W'(WORDS - 1));
   assign start_ready  = (state == ST_IDLE) && !flush;
   assign result_valid = (state == ST_DONE);
   assign busy         = (state != ST_IDLE);
   assign sum          = sum_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         c_out   <= 1'b0;
         ovf     <= 1'b0;
      end else if (flush && state != ST_IDLE) begin
         state   <= ST_IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         sum_reg <= '0;
         c_out   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid && start_ready) begin
                  // Subtract runs as a + ~b + ~borrow on the same adder.
                  a_reg <= a;
                  b_reg <= op_sub ? ~b : b;
                  carry <= op_sub ^ c_in;
                  idx   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_reg[idx] <= add_s;
               carry        <= add_c_top[1];
               idx          <= idx + CNT_W'(1);
               if (last_word) begin
                  c_out <= add_c_top[1];
                  ovf   <= add_c_top[1] ^ add_c_top[0];
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_multiword_seq.sv
// tb/tb_csa_multiword_seq.sv - scoreboard bench for csa_multiword_seq

module tb_csa_multiword_seq;

   localparam int WORDS = 4;
   localparam int W     = WORDS * 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         flush;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic         busy;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic rand_rr = 1'b0;

   always #5 clk = ~clk;

   csa_multiword_seq #(.WORDS(WORDS)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op_sub       (op_sub),
      .a            (a),
      .b            (b),
      .c_in         (c_in),
      .flush        (flush),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .sum          (sum),
      .c_out        (c_out),
      .ovf          (ovf),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
      exp_t e;
      e.sum   = s;
      e.c_out = co;
      e.ovf   = ov;
      return e;
   endfunction

   // Reference: plain integer arithmetic on sign-extended and zero-extended values.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, input logic sub);
      exp_t         e;
      logic [W+1:0] xa, xb, xc, r;
      logic [W:0]   u;
      xa = {{2{av[W-1]}}, av};
      xb = {{2{bv[W-1]}}, bv};
      xc = (W+2)'(ci);
      r  = sub ? (xa - xb - xc) : (xa + xb + xc);
      e.sum = r[W-1:0];
      e.ovf = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
      if (sub) begin
         e.c_out = ({1'b0, av} >= ({1'b0, bv} + (W+1)'(ci)));
      end else begin
         u       = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
         e.c_out = u[W];
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sub, input exp_t e);
      int t = 0;
      while (!start_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("start_ready_wait", W'(start_ready), W'(1));
      a = av; b = bv; c_in = ci; op_sub = sub;
      start_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start_valid = 1'b0;
      a = rnd(); b = rnd(); c_in = 1'($urandom); op_sub = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!result_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("result_valid_wait", W'(result_valid), W'(1));
   endtask

   always @(negedge clk) begin
      if (!rst && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", W'(result_valid), W'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", sum, e.sum);
            chk("c_out", W'(c_out), W'(e.c_out));
            chk("ovf", W'(ovf), W'(e.ovf));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rr) begin
         #1;
         result_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int           lat;
      int           seen;
      int           t;
      logic [W-1:0] av, bv, av2, bv2;
      logic         ci, sub, ci2, sub2;
      exp_t         e;

      rst = 1'b1; start_valid = 1'b0; op_sub = 1'b0; c_in = 1'b0;
      flush = 1'b0; result_ready = 1'b1; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start_ready", W'(start_ready), W'(1));
      chk("rst_result_valid", W'(result_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_sum", sum, W'(0));
      chk("rst_c_out", W'(c_out), W'(0));
      chk("rst_ovf", W'(ovf), W'(0));
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // Small add, with latency measured from the accept edge.
      send(W'(1200), W'(9999), 1'b0, 1'b0, mk(W'(11199), 1'b0, 1'b0));
      wait_valid(lat);
      chk("latency", W'(lat), W'(5));
      @(posedge clk); #1;
      chk("idle_after_result", W'(busy), W'(0));

      // Carry ripples through every word.
      send({W{1'b1}}, W'(0), 1'b1, 1'b0, mk(W'(0), 1'b1, 1'b0));
      wait_valid(lat);
      @(posedge clk); #1;

      // Signed overflow.
      av = {1'b0, {(W-1){1'b1}}};
      send(av, W'(1), 1'b0, 1'b0, mk({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1));
      wait_valid(lat);
      @(posedge clk); #1;

      // Subtract with borrow-in.
      send(W'(1000000), W'(1231233), 1'b1, 1'b1, mk(W'(0) - W'(231234), 1'b0, 1'b0));
      wait_valid(lat);
      @(posedge clk); #1;

      // Backpressure while a second command waits.
      av = rnd(); bv = rnd(); ci = 1'($urandom); sub = 1'($urandom);
      av2 = rnd(); bv2 = rnd(); ci2 = 1'($urandom); sub2 = 1'($urandom);
      result_ready = 1'b0;
      send(av, bv, ci, sub, model(av, bv, ci, sub));
      a = av2; b = bv2; c_in = ci2; op_sub = sub2; start_valid = 1'b1;
      wait_valid(lat);
      for (int i = 0; i < 3; i++) begin
         chk("bp_result_valid", W'(result_valid), W'(1));
         chk("bp_sum", sum, exp_q[0].sum);
         chk("bp_c_out", W'(c_out), W'(exp_q[0].c_out));
         chk("bp_ovf", W'(ovf), W'(exp_q[0].ovf));
         chk("bp_start_ready", W'(start_ready), W'(0));
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      exp_q.push_back(model(av2, bv2, ci2, sub2));
      @(posedge clk); #1;
      chk("bp_idle", W'(busy), W'(0));
      chk("bp_ready_again", W'(start_ready), W'(1));
      @(posedge clk); #1;
      chk("bp_next_accepted", W'(busy), W'(1));
      start_valid = 1'b0;
      wait_valid(lat);
      @(posedge clk); #1;

      // flush in IDLE blocks the accept.
      flush = 1'b1; start_valid = 1'b1;
      #1;
      chk("flush_idle_start_ready", W'(start_ready), W'(0));
      @(posedge clk); #1;
      chk("flush_idle_busy", W'(busy), W'(0));
      flush = 1'b0; start_valid = 1'b0;
      @(posedge clk); #1;

      // flush in RUN at word index 2.
      av = {W{1'b1}} ^ W'(5); bv = rnd();
      send(av, bv, 1'b0, 1'b0, model(av, bv, 1'b0, 1'b0));
      repeat (2) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      void'(exp_q.pop_back());
      chk("flush_busy", W'(busy), W'(0));
      chk("flush_result_valid", W'(result_valid), W'(0));
      chk("flush_sum", sum, W'(0));
      chk("flush_c_out", W'(c_out), W'(0));
      chk("flush_ovf", W'(ovf), W'(0));
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (result_valid) seen++;
      end
      chk("flush_no_result", W'(seen), W'(0));

      // Asynchronous reset mid-RUN, checked before the next clock edge.
      av = {W{1'b1}}; bv = {W{1'b1}};
      send(av, bv, 1'b1, 1'b0, model(av, bv, 1'b1, 1'b0));
      repeat (2) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      chk("arst_busy", W'(busy), W'(0));
      chk("arst_result_valid", W'(result_valid), W'(0));
      chk("arst_start_ready", W'(start_ready), W'(1));
      chk("arst_sum", sum, W'(0));
      chk("arst_c_out", W'(c_out), W'(0));
      chk("arst_ovf", W'(ovf), W'(0));
      #2 rst = 1'b0;
      @(posedge clk); #1;

      // Randomized traffic with random result backpressure.
      rand_rr = 1'b1;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0: begin av = rnd(); bv = rnd(); end
            1: begin av = {W{1'b1}}; bv = rnd(); end
            2: begin av = rnd(); bv = {W{1'b1}}; end
            default: begin av = {1'b0, {(W-1){1'b1}}} ^ W'($urandom_range(0, 3)); bv = W'($urandom_range(0, 3)); end
         endcase
         ci  = 1'($urandom);
         sub = 1'($urandom);
         send(av, bv, ci, sub, model(av, bv, ci, sub));
      end
      t = 0;
      while (exp_q.size() > 0 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      rand_rr = 1'b0;
      result_ready = 1'b1;
      chk("queue_drained", W'(exp_q.size()), W'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
